// File: rtl/ahbl_timer_capcmp_if.sv
// AHB-Lite bus bundle for the timer compare/capture slave.
interface ahbl_timer_capcmp_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HADDR, HTRANS, HREADY, HSIZE, HWRITE, HSEL, HWDATA,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HREADY, HSIZE, HWRITE, HSEL, HWDATA,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahbl_timer_capcmp.sv
// Timer compare/capture AHB-Lite slave: zero wait states (HREADYOUT tied 1), capture pin-to-FIFO 3 cycles,
// a full FIFO with no simultaneous pop drops the edge and flags OVF.
module ahbl_timer_capcmp #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahbl_timer_capcmp_if.slave  bus,
  input  logic [31:0]         TIMER_IN,
  input  logic                CAP_IN,
  output logic                IRQ
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_CMP    = 8'h04;
  localparam logic [7:0] A_STATUS = 8'h08;
  localparam logic [7:0] A_CAP    = 8'h0C;
  localparam logic [7:0] A_IM     = 8'h10;

  logic [7:0]    haddr_q;
  logic          htrans1_q, hwrite_q, hsel_q;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [31:0]   cmp_q, cmp_d;
  logic [2:0]    im_q, im_d;
  logic          match_q, match_d, ovf_q, ovf_d, irq_q, irq_d, eq_q;
  logic          cap_meta_q, cap_s_q, cap_prev_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   fifo_q [FIFO_DEPTH];

  logic wr, rd, eq, match_set, rise, fall, cap_hit, nempty, full, pop, push, ovf_set;
  logic wr_status;
  logic [4:0] level_rd;
  logic unused_bus;

  assign unused_bus = ^{bus.HADDR[31:8], bus.HTRANS[0], bus.HSIZE};

  assign wr        = htrans1_q & hsel_q & hwrite_q;
  assign rd        = htrans1_q & hsel_q & ~hwrite_q;
  assign wr_status = wr & (haddr_q == A_STATUS);

  assign eq        = (TIMER_IN == cmp_q);
  assign match_set = ctrl_q[0] & eq & ~eq_q;

  assign rise      = cap_s_q & ~cap_prev_q;
  assign fall      = ~cap_s_q & cap_prev_q;
  assign cap_hit   = ctrl_q[1] & ((rise & ctrl_q[2]) | (fall & ctrl_q[3]));

  assign nempty    = (level_q != '0);
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign pop       = rd & (haddr_q == A_CAP) & nempty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the edge.
  assign push      = cap_hit & (~full | pop);
  assign ovf_set   = cap_hit & full & ~pop;
  assign level_rd  = 5'(level_q);

  always_comb begin
    ctrl_d   = ctrl_q;
    cmp_d    = cmp_q;
    im_d     = im_q;
    if (wr) begin
      case (haddr_q)
        A_CTRL:  ctrl_d = bus.HWDATA[3:0];
        A_CMP:   cmp_d  = bus.HWDATA;
        A_IM:    im_d   = bus.HWDATA[2:0];
        default: ;
      endcase
    end
    // Hardware set beats a same-cycle W1C.
    match_d  = match_set | (match_q & ~(wr_status & bus.HWDATA[0]));
    ovf_d    = ovf_set   | (ovf_q   & ~(wr_status & bus.HWDATA[1]));
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    irq_d    = |({ovf_q, nempty, match_q} & im_q);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      haddr_q    <= '0;
      htrans1_q  <= 1'b0;
      hwrite_q   <= 1'b0;
      hsel_q     <= 1'b0;
      ctrl_q     <= '0;
      cmp_q      <= '0;
      im_q       <= '0;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      eq_q       <= 1'b0;
      cap_meta_q <= 1'b0;
      cap_s_q    <= 1'b0;
      cap_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      if (bus.HREADY) begin
        haddr_q   <= bus.HADDR[7:0];
        htrans1_q <= bus.HTRANS[1];
        hwrite_q  <= bus.HWRITE;
        hsel_q    <= bus.HSEL;
      end
      ctrl_q     <= ctrl_d;
      cmp_q      <= cmp_d;
      im_q       <= im_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      eq_q       <= eq;
      cap_meta_q <= CAP_IN;
      cap_s_q    <= cap_meta_q;
      cap_prev_q <= cap_s_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= TIMER_IN;
    end
  end

  always_comb begin
    case (haddr_q)
      A_CTRL:   bus.HRDATA = {28'b0, ctrl_q};
      A_CMP:    bus.HRDATA = cmp_q;
      A_STATUS: bus.HRDATA = {23'b0, level_rd, 1'b0, nempty, ovf_q, match_q};
      A_CAP:    bus.HRDATA = nempty ? fifo_q[rd_ptr_q] : 32'h0;
      A_IM:     bus.HRDATA = {29'b0, im_q};
      default:  bus.HRDATA = 32'hBADDBEEF;
    endcase
  end

  assign bus.HREADYOUT = 1'b1;
  assign IRQ           = irq_q;
endmodule

// File: tb/tb_ahbl_timer_capcmp.sv
// Directed bench for ahbl_timer_capcmp: compare, capture FIFO, overflow, W1C races and reset.
module tb_ahbl_timer_capcmp;
  logic        HCLK;
  logic        HRESETn;
  logic [31:0] timer;
  logic        cap;
  logic        IRQ;
  bit          tmr_inc;
  int          n_cmp;
  int          n_err;
  logic [31:0] r;
  logic [31:0] stamps [5];
  logic [31:0] s5;

  localparam logic [7:0] A_CTRL = 8'h00, A_CMP = 8'h04, A_STATUS = 8'h08,
                         A_CAP = 8'h0C, A_IM = 8'h10;

  ahbl_timer_capcmp_if ahb ();

  ahbl_timer_capcmp #(.FIFO_DEPTH(4)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (ahb),
    .TIMER_IN(timer),
    .CAP_IN  (cap),
    .IRQ     (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    if (tmr_inc) timer = timer + 1;
  endtask

  task automatic drive_addr(input logic [7:0] a, input logic w);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = w;
    ahb.HADDR  = {24'h0, a};
  endtask

  task automatic drive_idle();
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    drive_addr(a, 1'b1);
    tick();
    drive_idle();
    ahb.HWDATA = d;
    tick();
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    drive_addr(a, 1'b0);
    tick();
    drive_idle();
    d = ahb.HRDATA;
    tick();
  endtask

  // One rising pulse on the pin; stamp is the count seen in the detect cycle.
  task automatic cap_pulse(output logic [31:0] stamp);
    cap = 1'b1;
    stamp = timer + 32'd2;
    repeat (3) tick();
    cap = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    HRESETn = 1'b0; timer = '0; cap = 1'b0; tmr_inc = 1'b0;
    ahb.HADDR = '0; ahb.HTRANS = '0; ahb.HREADY = 1'b1; ahb.HSIZE = 3'b010;
    ahb.HWRITE = 1'b0; ahb.HSEL = 1'b0; ahb.HWDATA = '0;
    repeat (3) tick();
    check_eq("rst_hrdata", ahb.HRDATA, 32'h0);
    check_eq("rst_irq", {31'b0, IRQ}, 32'h0);
    check_eq("hreadyout", {31'b0, ahb.HREADYOUT}, 32'h1);
    HRESETn = 1'b1;
    tick();

    // Compare match on counting timer
    bus_write(A_CMP, 32'h64);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_IM, 32'h1);
    timer = 32'h60; tmr_inc = 1'b1;
    for (int i = 0; i < 8 && timer != 32'h63; i++) tick();
    drive_addr(A_STATUS, 1'b0);
    check_eq("t1_irq_pre", {31'b0, IRQ}, 32'h0);
    tick();
    check_eq("t1_match_at64", ahb.HRDATA, 32'h0);
    tick();
    check_eq("t1_match_set", ahb.HRDATA, 32'h1);
    check_eq("t1_irq_lag", {31'b0, IRQ}, 32'h0);
    tick();
    check_eq("t1_irq_set", {31'b0, IRQ}, 32'h1);
    drive_idle();
    tmr_inc = 1'b0; timer = 32'h64;
    tick(); tick();
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, r);
    check_eq("t1_w1c", r, 32'h0);
    repeat (3) tick();
    bus_read(A_STATUS, r);
    check_eq("t1_hold64", r, 32'h0);
    check_eq("t1_irq_clr", {31'b0, IRQ}, 32'h0);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_IM, 32'h0);

    // Single capture, exact latency
    bus_write(A_CTRL, 32'h6);
    timer = 32'h1000; tmr_inc = 1'b1;
    tick();
    cap = 1'b1;
    s5 = timer + 32'd2;
    drive_addr(A_STATUS, 1'b0);
    tick();
    check_eq("t2_lvl_c1", ahb.HRDATA, 32'h0);
    tick();
    check_eq("t2_lvl_c2", ahb.HRDATA, 32'h0);
    tick();
    check_eq("t2_lvl_c3", ahb.HRDATA, 32'h14);
    drive_idle();
    bus_read(A_CAP, r);
    check_eq("t2_stamp", r, s5);
    bus_read(A_STATUS, r);
    check_eq("t2_lvl_after", r, 32'h0);

    // Overflow: five edges into a four-deep FIFO
    cap = 1'b0;
    repeat (4) tick();
    bus_write(A_IM, 32'h4);
    for (int i = 0; i < 5; i++) cap_pulse(stamps[i]);
    bus_read(A_STATUS, r);
    check_eq("t3_full_ovf", r, 32'h46);
    check_eq("t3_irq_ovf", {31'b0, IRQ}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus_read(A_CAP, r);
      check_eq($sformatf("t3_pop%0d", i), r, stamps[i]);
    end
    bus_read(A_CAP, r);
    check_eq("t3_pop_empty", r, 32'h0);
    bus_read(A_STATUS, r);
    check_eq("t3_ovf_sticky", r, 32'h2);
    bus_write(A_STATUS, 32'h2);
    bus_write(A_IM, 32'h0);
    bus_read(A_STATUS, r);
    check_eq("t3_ovf_w1c", r, 32'h0);

    // Full FIFO: pop and push in the same cycle
    for (int i = 0; i < 4; i++) cap_pulse(stamps[i]);
    cap = 1'b1;
    s5 = timer + 32'd2;
    tick();
    drive_addr(A_CAP, 1'b0);
    tick();
    drive_idle();
    r = ahb.HRDATA;
    tick();
    check_eq("t4_pop_head", r, stamps[0]);
    bus_read(A_STATUS, r);
    check_eq("t4_lvl_noovf", r, 32'h44);
    for (int i = 1; i < 4; i++) begin
      bus_read(A_CAP, r);
      check_eq($sformatf("t4_pop%0d", i), r, stamps[i]);
    end
    bus_read(A_CAP, r);
    check_eq("t4_tail", r, s5);
    bus_read(A_STATUS, r);
    check_eq("t4_empty", r, 32'h0);

    // MATCH set racing a W1C; unmapped read
    cap = 1'b0;
    tmr_inc = 1'b0; timer = 32'h1FF;
    bus_write(A_CMP, 32'h200);
    bus_write(A_CTRL, 32'h1);
    tick(); tick();
    drive_addr(A_STATUS, 1'b1);
    tick();
    drive_idle();
    ahb.HWDATA = 32'h1;
    timer = 32'h200;
    tick();
    bus_read(A_STATUS, r);
    check_eq("t5_set_wins", r, 32'h1);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, r);
    check_eq("t5_w1c_after", r, 32'h0);
    bus_read(A_CMP, r);
    check_eq("t5_cmp_rb", r, 32'h200);
    bus_read(8'h20, r);
    check_eq("t5_unmapped", r, 32'hBADDBEEF);

    // Reset with captures pending and one edge in flight
    tmr_inc = 1'b1;
    bus_write(A_CTRL, 32'h6);
    bus_write(A_IM, 32'h2);
    for (int i = 0; i < 2; i++) cap_pulse(stamps[i]);
    check_eq("t6_irq_nempty", {31'b0, IRQ}, 32'h1);
    bus_read(A_STATUS, r);
    check_eq("t6_lvl2", r, 32'h24);
    cap = 1'b1;
    tick();
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    check_eq("t6_irq_rst", {31'b0, IRQ}, 32'h0);
    check_eq("t6_hrdata_rst", ahb.HRDATA, 32'h0);
    repeat (4) tick();
    bus_read(A_STATUS, r);
    check_eq("t6_status_rst", r, 32'h0);
    bus_read(A_IM, r);
    check_eq("t6_im_rst", r, 32'h0);
    bus_read(A_CMP, r);
    check_eq("t6_cmp_rst", r, 32'h0);
    bus_read(A_CAP, r);
    check_eq("t6_cap_rst", r, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
